fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Sequences instruction fetch out of program_memory for the RV32IC core. It drives the byte address, splits each returned word into one 32-bit or one 16-bit (compressed) instruction, and advances the PC by 4 or 2. Fetched instructions are queued in a small FIFO and presented to decode with a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and restart fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
DEPTH, 2, instruction FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
fetch_en  in  1  fetch permitted this cycle
mem_addr  out  32  byte address to program_memory (combinational read)
mem_rdata  in  32  little-endian word at mem_addr..mem_addr+3, same cycle
redirect_valid  in  1  flush and restart at redirect_pc
redirect_pc  in  32  redirect target
out_valid  out  1  FIFO head valid
out_ready  in  1  decode accepts head
out_instr  out  32  instruction; upper 16 bits zero when compressed
out_pc  out  32  PC of head instruction
out_compressed  out  1  head is a 16-bit instruction
fault  out  1  sticky misaligned-target flag
fetch_count  out  32  instructions accepted by decode since reset

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. On reset: pc=RESET_PC, FIFO empty, out_valid=0, out_instr/out_pc=0, out_compressed=0, fault=0, fetch_count=0.
- mem_addr = pc register, always driven. Memory read is zero-latency.
- Decode: compressed iff mem_rdata[1:0] != 2'b11. Push entry {pc, compressed ? {16'h0, mem_rdata[15:0]} : mem_rdata, compressed}. pc_next = pc + (compressed ? 2 : 4), 32-bit wrap-around.
- Pop: occurs when out_valid && out_ready. fetch_count increments on each pop and wraps at 2^32.
- Push condition: fetch_en && !fault && !redirect_valid && (count < DEPTH || pop). With pop and push in the same cycle, count is unchanged. When full without pop: no push and pc holds.
- Outputs: head-of-FIFO registers. A push into an empty FIFO makes out_valid=1 the next cycle. Output fields hold stable while out_valid && !out_ready.
- Redirect (highest priority): in cycle N, the FIFO is cleared, any same-cycle pop is discarded (fetch_count not incremented), and no push occurs. pc <= redirect_pc. At cycle N+1, mem_addr = redirect_pc and the push of the target happens. At N+2, out_valid=1 with out_pc=redirect_pc. Back-to-back redirects: the last one wins.
- Misaligned target: redirect_pc[0]=1 sets fault=1, clears the FIFO and stops all pushes. fault clears only on a later redirect with bit0=0, or on reset.
- fetch_en=0: no pushes, pc holds, FIFO drains normally.
- Reset asserted mid-stream overrides pop, push and redirect in that cycle.
- FIFO: circular buffer with read/write pointers and a count of width $clog2(DEPTH)+1.

Decomposition:
- fetch_pkg: fetch_entry_t struct {pc[31:0], instr[31:0], compressed}; constant ILEN_OPCODE_FULL=2'b11; function is_compressed(logic [15:0]).
- Sub-module fetch_fifo (parameterised DEPTH, type fetch_entry_t): push/pop/flush/full/empty/head. fetch_sequencer owns the pc, push/redirect/fault logic and fetch_count.

Test Plan:
1. Mixed stream: RESET_PC=0, memory words 0x00200093, 0x05934529, 0x061D0050, out_ready=1. Required sequence: (pc 0, 0x00200093, c=0), (pc 4, 0x00004529, c=1), (pc 6, 0x00500593, c=0), (pc 10, 0x0000061D, c=1). mem_addr must step 0, 4, 6, 10.
2. Backpressure: out_ready=0 for 5 cycles. FIFO fills to DEPTH, pc holds at 6, and out_pc stays 0 with stable fields. Releasing out_ready delivers all instructions in order with none lost or duplicated.
3. Redirect during pop: FIFO full, with out_ready=1 and redirect_valid=1 (redirect_pc=0x20) in cycle N. out_valid=0 at N+1, out_pc=0x20 at N+2, and fetch_count unchanged by cycle N.
4. Misaligned redirect to 0x21: fault=1 and out_valid=0 indefinitely. A following redirect to 0x24 clears fault, and out_pc=0x24 appears two cycles later.
5. Reset mid-stream: assert reset for 1 cycle while out_valid=1 with a pending redirect. Every output takes its reset value and fetch restarts at RESET_PC.
6. Wrap: redirect to 0xFFFF_FFFC where the word there is 32-bit. The next fetch address is 0x0000_0000.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and helpers for the instruction fetch path.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        compressed;
  } fetch_entry_t;

  // Low two bits of a 32-bit (non-compressed) RV32 instruction.
  localparam logic [1:0] ILEN_OPCODE_FULL = 2'b11;

  function automatic logic is_compressed(input logic [15:0] half);
    return (half & {14'h0, ILEN_OPCODE_FULL}) != {14'h0, ILEN_OPCODE_FULL};
  endfunction

endpackage

// File: rtl/fetch_sequencer_fifo.sv
// Circular-buffer FIFO holding fetched instructions; head is the read slot.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  input  logic   flush,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; flush wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is cleared on reset so the head reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives pc to memory, splits 16/32-bit
// instructions, queues them for decode, and handles redirects and faults.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_compressed,
  output logic        fault,
  output logic [31:0] fetch_count
);

  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  fetch_count_q, fetch_count_d;

  logic         fifo_full, fifo_empty;
  logic         push, pop;
  logic         compressed;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  // Split the returned word into the entry pushed this cycle.
  always_comb begin
    compressed            = is_compressed(mem_rdata[15:0]);
    push_entry.pc         = pc_q;
    push_entry.instr      = compressed ? {16'h0, mem_rdata[15:0]} : mem_rdata;
    push_entry.compressed = compressed;
  end

  // Handshake, pc advance, redirect/fault handling and pop counting.
  // A redirect discards any same-cycle pop, so pop is masked before it
  // feeds either the FIFO or fetch_count.
  always_comb begin
    pop  = !fifo_empty && out_ready && !redirect_valid;
    push = fetch_en && !fault_q && !redirect_valid && (!fifo_full || pop);

    pc_d          = pc_q;
    fault_d       = fault_q;
    fetch_count_d = fetch_count_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      fault_d = redirect_pc[0];
    end else if (push) begin
      pc_d = pc_q + (compressed ? 32'd2 : 32'd4);
    end

    if (pop) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head)
  );

  assign mem_addr       = pc_q;
  assign out_valid      = !fifo_empty;
  assign out_instr      = head.instr;
  assign out_pc         = head.pc;
  assign out_compressed = head.compressed;
  assign fault          = fault_q;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a byte-addressed memory model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_compressed;
  logic        fault;
  logic [31:0] fetch_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  // 256-byte memory aliased over the address space; little-endian, zero latency.
  always_comb begin
    logic [7:0] a;
    a         = mem_addr[7:0];
    mem_rdata = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  end

  fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_compressed (out_compressed),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  typedef struct {
    logic        rst;
    logic        fen;
    logic        rdy;
    logic        chk;
    logic        chkhead;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        c;
    logic [31:0] fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic fen, input logic rdy,
                              input logic chk, input logic chkhead,
                              input logic [31:0] addr, input logic v,
                              input logic [31:0] pc, input logic [31:0] instr,
                              input logic c, input logic [31:0] fc);
    vec_t r;
    r.rst = rst; r.fen = fen; r.rdy = rdy; r.chk = chk; r.chkhead = chkhead;
    r.addr = addr; r.v = v; r.pc = pc; r.instr = instr; r.c = c; r.fc = fc;
    return r;
  endfunction

  task automatic put_word(input logic [7:0] a, input logic [31:0] w);
    mem[a]        = w[7:0];
    mem[a + 8'd1] = w[15:8];
    mem[a + 8'd2] = w[23:16];
    mem[a + 8'd3] = w[31:24];
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fen, input logic rdy,
                       input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    reset          = rst;
    fetch_en       = fen;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] addr,
                             input logic v, input logic f, input logic [31:0] fc,
                             input logic chkhead, input logic [31:0] pc,
                             input logic [31:0] instr, input logic c);
    cmp({tag, ".mem_addr"}, mem_addr, addr);
    cmp({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, v});
    cmp({tag, ".fault"}, {31'h0, fault}, {31'h0, f});
    cmp({tag, ".fetch_count"}, fetch_count, fc);
    if (chkhead) begin
      cmp({tag, ".out_pc"}, out_pc, pc);
      cmp({tag, ".out_instr"}, out_instr, instr);
      cmp({tag, ".out_compressed"}, {31'h0, out_compressed}, {31'h0, c});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i += 4) put_word(8'(i), 32'h0000_0013);
    put_word(8'h00, 32'h0020_0093);
    put_word(8'h04, 32'h0593_4529);
    put_word(8'h08, 32'h061D_0050);
    put_word(8'hFC, 32'h1234_5677);

    // Mixed 32/16-bit stream with decode always ready.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'd0,  0, 32'd0,  32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'd4,  1, 32'd0,  32'h0020_0093, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'd6,  1, 32'd4,  32'h0000_4529, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'd10, 1, 32'd6,  32'h0050_0593, 0, 2));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'd12, 1, 32'd10, 32'h0000_061D, 1, 3));
    // Backpressure: five cycles not ready, FIFO fills and pc holds at 6.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 32'd0, 0, 32'd0, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 32'd4, 1, 32'd0, 32'h0020_0093, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 32'd6, 1, 32'd0, 32'h0020_0093, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 32'd6, 1, 32'd0, 32'h0020_0093, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 32'd6, 1, 32'd0, 32'h0020_0093, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'd6,  1, 32'd0,  32'h0020_0093, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'd10, 1, 32'd4,  32'h0000_4529, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'd12, 1, 32'd6,  32'h0050_0593, 0, 2));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'd16, 1, 32'd10, 32'h0000_061D, 1, 3));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'd20, 1, 32'd12, 32'h0000_0013, 0, 4));
    // fetch_en low: pc holds while the FIFO drains.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 32'd0, 0, 32'd0, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 32'd4, 1, 32'd0, 32'h0020_0093, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'd6, 1, 32'd0, 32'h0020_0093, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'd6, 1, 32'd4, 32'h0000_4529, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 32'd6, 0, 32'd0, 32'h0000_0000, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'd6, 0, 32'd0, 32'h0000_0000, 0, 2));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fen, vecs[i].rdy, 1'b0, 32'h0);
      if (vecs[i].chk)
        check_state($sformatf("vec%0d", i), vecs[i].addr, vecs[i].v, 1'b0, vecs[i].fc,
                    vecs[i].chkhead, vecs[i].pc, vecs[i].instr, vecs[i].c);
    end

    // Redirect while full and popping: pop discarded, target two cycles later.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check_state("redir.full", 32'd6, 1, 0, 0, 1, 32'd0, 32'h0020_0093, 0);
    drive(0, 1, 1, 1, 32'h20);
    check_state("redir.N", 32'd6, 1, 0, 0, 1, 32'd0, 32'h0020_0093, 0);
    drive(0, 1, 1, 0, 0);
    check_state("redir.N1", 32'h20, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    check_state("redir.N2", 32'h24, 1, 0, 0, 1, 32'h20, 32'h0000_0013, 0);

    // Misaligned redirect faults until an aligned redirect clears it.
    drive(0, 1, 1, 1, 32'h21);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0);
      check_state($sformatf("fault.hold%0d", k), 32'h21, 0, 1, 1, 0, 0, 0, 0);
    end
    drive(0, 1, 1, 1, 32'h24);
    check_state("fault.clr_cyc", 32'h21, 0, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    check_state("fault.clr1", 32'h24, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    check_state("fault.clr2", 32'h28, 1, 0, 1, 1, 32'h24, 32'h0000_0013, 0);

    // Reset overrides a pending redirect and a valid head.
    drive(1, 1, 1, 1, 32'h40);
    drive(0, 1, 1, 0, 0);
    check_state("rst.mid", 32'd0, 0, 0, 0, 1, 32'd0, 32'h0000_0000, 0);
    drive(0, 1, 1, 0, 0);
    check_state("rst.restart", 32'd4, 1, 0, 0, 1, 32'd0, 32'h0020_0093, 0);

    // pc wraps from the top of the address space to zero.
    drive(0, 1, 1, 1, 32'hFFFF_FFFC);
    drive(0, 1, 1, 0, 0);
    check_state("wrap.tgt", 32'hFFFF_FFFC, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    check_state("wrap.next", 32'h0, 1, 0, 1, 1, 32'hFFFF_FFFC, 32'h1234_5677, 0);
    drive(0, 1, 1, 0, 0);
    check_state("wrap.after", 32'h4, 1, 0, 2, 1, 32'h0, 32'h0020_0093, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
